semaforo_multifase: RTL and testbench
=====================================

# semaforo_multifase

Parametrised traffic-light controller for an intersection of `N_VIAS` approaches, the successor of the single-approach green/yellow/red controller. Only one approach is green at a time. Round-robin arbitration serves latched vehicle requests. Each phase has programmable minimum and maximum green, yellow and all-red clearance times. A fixed-time/actuated mode input and a flashing-yellow night mode are provided. The block sits between the vehicle-sensor synchronisers and the lamp drivers, and all timing is counted in `clk` cycles.

## Interface
- `N_VIAS`, 2: number of approaches; legal range 2..8.
- `CW`, 32: width of the phase counter.
- `T_VERDE_MIN`, 250_000_000: minimum green time, in cycles.
- `T_VERDE_MAX`, 750_000_000: maximum green time, in cycles; must be ≥ `T_VERDE_MIN`.
- `T_AMARELO`, 50_000_000: yellow time, in cycles.
- `T_VERMELHO`, 25_000_000: all-red clearance time, in cycles.
- `T_PISCA`, 25_000_000: half-period of the flashing yellow, in cycles.

Ports:
- `clk` in 1: the single clock.
- `res` in 1: reset, asynchronous and active-high.
- `car` in `N_VIAS`: per-approach vehicle request; already synchronised, level-sensitive.
- `modo` in 1: 0 = actuated, 1 = fixed-time.
- `pisca` in 1: 1 = night mode with flashing yellow.
- `verde` out `N_VIAS`: per-approach green lamp.
- `amarelo` out `N_VIAS`: per-approach yellow lamp.
- `vermelho` out `N_VIAS`: per-approach red lamp.
- `via_ativa` out `clog2(N_VIAS)`: index of the approach currently served.

## Operation
- States are `TODOS_VERM`, `VERDE`, `AMARELO` and `PISCA`.
- `cnt` counts cycles spent in the current state and clears on every state change.
- `pedido[i]` is set when `car[i]` is 1. It is cleared in the cycle that via i enters `VERDE`. Set takes priority over clear only for other vias.

Transitions:
- `TODOS_VERM` → `VERDE`, when `cnt == T_VERMELHO-1`.
  - The winner is the first via with `pedido` set, searching cyclically from `via_ativa+1`.
  - If no via has `pedido` set, the winner is `via_ativa+1` in fixed mode, or `via_ativa` in actuated mode.
- `VERDE` → `AMARELO`:
  - Fixed mode: when `cnt == T_VERDE_MAX-1`.
  - Actuated mode: when `cnt ≥ T_VERDE_MIN-1` and any other via has `pedido` set, or when `cnt == T_VERDE_MAX-1` and any other via has `pedido` set.
  - Actuated mode with no other request: stay in `VERDE` indefinitely, with `cnt` saturating at `T_VERDE_MAX-1`.
- `AMARELO` → `TODOS_VERM`, when `cnt == T_AMARELO-1`.
- Any state → `PISCA`, in the cycle after `pisca` is sampled high. `pisca` has priority over every other transition.
- `PISCA` → `TODOS_VERM`, when `pisca` is sampled low. `cnt` restarts, so a full clearance precedes the next green.

Outputs are Moore, decoded from the registered state:
- `VERDE`: `verde[via_ativa]`=1, all other vias red.
- `AMARELO`: `amarelo[via_ativa]`=1, all other vias red.
- `TODOS_VERM`: all `vermelho`=1.
- `PISCA`: all `verde` and `vermelho` are 0. All `amarelo` bits equal a toggle flag that inverts every `T_PISCA` cycles; the flag is 1 on entry.

Invariants:
- Exactly one lamp is lit per via outside `PISCA`.
- Never more than one `verde` bit is set.
- `cnt` never wraps.

## Timing
- Reset values: state `TODOS_VERM`, `via_ativa`=`N_VIAS-1` (so the first round-robin search starts at via 0), `cnt`=0, `pedido`=0, `vermelho` all 1, `verde`=0, `amarelo`=0.
- Reset mid-phase forces the reset values immediately and asynchronously.

Phase lengths:
- `TODOS_VERM` lasts exactly `T_VERMELHO` cycles.
- `AMARELO` lasts exactly `T_AMARELO` cycles.
- Fixed-mode `VERDE` lasts exactly `T_VERDE_MAX` cycles.

Latencies:
- `car` to `pedido`: 1 cycle.
- `pedido` influences a transition in the following cycle.
- `pisca` high to `PISCA` outputs: 1 cycle.

Boundary conditions:
- If `car[i]` rises for the green via itself, `pedido[i]` is not latched.
- If `car` of several vias rises in the same cycle, the via nearest cyclically after `via_ativa` wins.
- If `pisca` drops during `PISCA`, the block enters `TODOS_VERM` on the next edge; the toggle flag clears.

## Structure
- Shared package `semaforo_pkg` holds:
  - the state encoding constants `TODOS_VERM`=2'b00, `VERDE`=2'b01, `AMARELO`=2'b10, `PISCA`=2'b11;
  - the default timing constants.
- Sub-module `seletor_rr`: combinational round-robin picker over `N_VIAS`.
  - Inputs: `pedido`, `base`.
  - Outputs: `valido`, `indice`.
- Everything else lives in the top module: the FSM, the counter and the request latches.

## Test plan
Run all scenarios with `N_VIAS`=3 and T_VERDE_MIN/MAX/AMARELO/VERMELHO/PISCA = 4/10/2/3/2.

- Reset, then `car`=0 with `modo`=1:
  - All red for 3 cycles.
  - Then vias 0, 1, 2 green in turn, each for 10 cycles, followed by 2 cycles yellow and 3 cycles all red.
- `modo`=0, `car`=0 after first green on via 0:
  - Via 0 stays green for more than 50 cycles.
- At green-cycle 1, assert `car[2]` for one cycle:
  - Via 0 goes yellow at `cnt`=3.
  - Via 2 (not via 1) is green after clearance.
- `car`=3'b110 in the same cycle while via 0 is green:
  - Served order is via 1, then via 2.
- `pisca`=1 mid-green:
  - Next cycle all `amarelo` are 1, toggling every 2 cycles, with `verde`/`vermelho` 0.
  - `pisca`=0: all red for 3 cycles, then a green phase.
- Assert `res` asynchronously mid-yellow:
  - Outputs go to all red immediately, without waiting for a clock edge.
  - `pedido` clears and `via_ativa` returns to 2.

Source files
------------

// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared types and default timing for the
// multi-approach traffic-light controller.
package semaforo_pkg;

    typedef enum logic [1:0] {
        TODOS_VERM = 2'b00,
        VERDE      = 2'b01,
        AMARELO    = 2'b10,
        PISCA      = 2'b11
    } estado_t;

    localparam int unsigned T_VERDE_MIN_DEF = 250_000_000;
    localparam int unsigned T_VERDE_MAX_DEF = 750_000_000;
    localparam int unsigned T_AMARELO_DEF   = 50_000_000;
    localparam int unsigned T_VERMELHO_DEF  = 25_000_000;
    localparam int unsigned T_PISCA_DEF     = 25_000_000;

endpackage

// File: rtl/seletor_rr.sv
// seletor_rr: combinational round-robin picker; returns the first
// requesting approach found searching cyclically from base.
module seletor_rr #(
    parameter int N_VIAS = 2
) (
    input  logic [N_VIAS-1:0]         pedido,
    input  logic [$clog2(N_VIAS)-1:0] base,
    output logic                      valido,
    output logic [$clog2(N_VIAS)-1:0] indice
);

    localparam int IW = $clog2(N_VIAS);

    // scan offsets from farthest to nearest so the nearest hit wins
    always_comb begin
        int j;
        j      = 0;
        valido = |pedido;
        indice = base;
        for (int k = N_VIAS - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= N_VIAS) j = j - N_VIAS;
            if (pedido[IW'(j)]) indice = IW'(j);
        end
    end

endmodule

// File: rtl/semaforo_multifase.sv
// semaforo_multifase: round-robin traffic-light controller for
// N_VIAS approaches with actuated/fixed modes and night flashing.
module semaforo_multifase
    import semaforo_pkg::*;
#(
    parameter int          N_VIAS      = 2,
    parameter int          CW          = 32,
    parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
    parameter int unsigned T_VERDE_MAX = T_VERDE_MAX_DEF,
    parameter int unsigned T_AMARELO   = T_AMARELO_DEF,
    parameter int unsigned T_VERMELHO  = T_VERMELHO_DEF,
    parameter int unsigned T_PISCA     = T_PISCA_DEF
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic [N_VIAS-1:0]         car,
    input  logic                      modo,
    input  logic                      pisca,
    output logic [N_VIAS-1:0]         verde,
    output logic [N_VIAS-1:0]         amarelo,
    output logic [N_VIAS-1:0]         vermelho,
    output logic [$clog2(N_VIAS)-1:0] via_ativa
);

    localparam int IW = $clog2(N_VIAS);

    localparam logic [CW-1:0] FIM_VM  = CW'(T_VERMELHO - 1);
    localparam logic [CW-1:0] FIM_AM  = CW'(T_AMARELO - 1);
    localparam logic [CW-1:0] MIN_VD  = CW'(T_VERDE_MIN - 1);
    localparam logic [CW-1:0] MAX_VD  = CW'(T_VERDE_MAX - 1);
    localparam logic [CW-1:0] FIM_PS  = CW'(T_PISCA - 1);

    estado_t           estado_q, estado_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_VIAS-1:0] pedido_q, pedido_d;
    logic [IW-1:0]     via_q, via_d;
    logic              flag_q, flag_d;

    logic [IW-1:0]     prox;
    logic [N_VIAS-1:0] ativa_oh;
    logic [N_VIAS-1:0] mascara;
    logic              outros;
    logic              entra_verde;
    logic              rr_valido;
    logic [IW-1:0]     rr_indice;

    assign prox     = (via_q == IW'(N_VIAS - 1)) ? '0 : via_q + IW'(1);
    assign ativa_oh = N_VIAS'(1) << via_q;
    assign outros   = |(pedido_q & ~ativa_oh);

    assign entra_verde = (estado_q == TODOS_VERM) && (estado_d == VERDE);

    seletor_rr #(
        .N_VIAS (N_VIAS)
    ) u_rr (
        .pedido (pedido_q),
        .base   (prox),
        .valido (rr_valido),
        .indice (rr_indice)
    );

    // state, phase counter, request latches and flash flag
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            estado_q <= TODOS_VERM;
            cnt_q    <= '0;
            pedido_q <= '0;
            via_q    <= IW'(N_VIAS - 1);
            flag_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            pedido_q <= pedido_d;
            via_q    <= via_d;
            flag_q   <= flag_d;
        end
    end

    // next phase; night mode overrides everything
    always_comb begin
        estado_d = estado_q;
        if (pisca) begin
            estado_d = PISCA;
        end else begin
            unique case (estado_q)
                TODOS_VERM: if (cnt_q == FIM_VM) estado_d = VERDE;
                VERDE: begin
                    if (modo) begin
                        if (cnt_q == MAX_VD) estado_d = AMARELO;
                    end else if (outros && cnt_q >= MIN_VD) begin
                        estado_d = AMARELO;
                    end
                end
                AMARELO:    if (cnt_q == FIM_AM) estado_d = TODOS_VERM;
                PISCA:      estado_d = TODOS_VERM;
            endcase
        end
    end

    // counter, winner selection, request latching and flash toggle
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (estado_d != estado_q) begin
            cnt_d = '0;
        end else if (estado_q == VERDE && cnt_q == MAX_VD) begin
            cnt_d = cnt_q;
        end else if (estado_q == PISCA && cnt_q >= FIM_PS) begin
            cnt_d = '0;
        end

        via_d = via_q;
        if (entra_verde) begin
            if (rr_valido)  via_d = rr_indice;
            else if (modo)  via_d = prox;
        end

        mascara  = (estado_q == VERDE) ? ativa_oh : '0;
        pedido_d = pedido_q | (car & ~mascara);
        if (entra_verde) pedido_d = pedido_d & ~(N_VIAS'(1) << via_d);

        flag_d = 1'b0;
        if (estado_d == PISCA) begin
            if (estado_q != PISCA)    flag_d = 1'b1;
            else if (cnt_q >= FIM_PS) flag_d = ~flag_q;
            else                      flag_d = flag_q;
        end
    end

    // Moore lamp decode from the registered phase
    always_comb begin
        verde    = '0;
        amarelo  = '0;
        vermelho = '0;
        unique case (estado_q)
            TODOS_VERM: vermelho = '1;
            VERDE: begin
                verde    = ativa_oh;
                vermelho = ~ativa_oh;
            end
            AMARELO: begin
                amarelo  = ativa_oh;
                vermelho = ~ativa_oh;
            end
            PISCA: amarelo = {N_VIAS{flag_q}};
        endcase
    end

    assign via_ativa = via_q;

endmodule

// File: tb/tb_semaforo_multifase.sv
// tb_semaforo_multifase: directed vector table plus randomized run
// against a behavioural model of the intersection.
module tb_semaforo_multifase;

    localparam int N    = 3;
    localparam int MINV = 4;
    localparam int MAXV = 10;
    localparam int AM   = 2;
    localparam int VM   = 3;
    localparam int PS   = 2;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [2:0] car = 3'b000;
    logic       modo = 1'b1;
    logic       pisca = 1'b0;
    logic [2:0] verde, amarelo, vermelho;
    logic [1:0] via_ativa;

    int checks = 0;
    int errors = 0;

    logic [10:0] obs;

    int       m_ph;
    int       m_t;
    int       m_via;
    bit [2:0] m_req;

    typedef struct {
        bit          rst;
        logic [2:0]  car;
        logic        modo;
        logic        pisca;
        int          n;
        logic [10:0] exp;
    } vec_t;

    vec_t tab[$];

    always #5 clk = ~clk;

    semaforo_multifase #(
        .N_VIAS      (N),
        .CW          (32),
        .T_VERDE_MIN (MINV),
        .T_VERDE_MAX (MAXV),
        .T_AMARELO   (AM),
        .T_VERMELHO  (VM),
        .T_PISCA     (PS)
    ) dut (
        .clk       (clk),
        .res       (res),
        .car       (car),
        .modo      (modo),
        .pisca     (pisca),
        .verde     (verde),
        .amarelo   (amarelo),
        .vermelho  (vermelho),
        .via_ativa (via_ativa)
    );

    task automatic cmp(input string nm, input logic [10:0] act,
                       input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual v/a/r/via=%b_%b_%b_%0d required=%b_%b_%b_%0d",
                     nm, act[10:8], act[7:5], act[4:2], act[1:0],
                     exp[10:8], exp[7:5], exp[4:2], exp[1:0]);
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [2:0] v, a, r, oh;
        oh = 3'b001 << m_via;
        v = '0;
        a = '0;
        r = '0;
        case (m_ph)
            0: r = 3'b111;
            1: begin v = oh; r = ~oh; end
            2: begin a = oh; r = ~oh; end
            default: a = (((m_t / PS) % 2) == 0) ? 3'b111 : 3'b000;
        endcase
        return {v, a, r, 2'(m_via)};
    endfunction

    task automatic model_step(input logic [2:0] c, input logic m,
                              input logic p);
        int       nph;
        int       w;
        bit [2:0] nreq;
        bit       other;
        other = 0;
        for (int i = 0; i < N; i++)
            if (m_req[i] && i != m_via) other = 1;
        nreq = m_req;
        for (int i = 0; i < N; i++)
            if (c[i] && !(m_ph == 1 && i == m_via)) nreq[i] = 1;
        nph = m_ph;
        if (p) nph = 3;
        else case (m_ph)
            0: if (m_t >= VM - 1) nph = 1;
            1: if (m ? (m_t >= MAXV - 1) : (other && m_t >= MINV - 1)) nph = 2;
            2: if (m_t >= AM - 1) nph = 0;
            default: nph = 0;
        endcase
        if (m_ph == 0 && nph == 1) begin
            w = m ? (m_via + 1) % N : m_via;
            for (int k = N; k >= 1; k--)
                if (m_req[(m_via + k) % N]) w = (m_via + k) % N;
            m_via = w;
            nreq[w] = 0;
        end
        m_t   = (nph != m_ph) ? 0 : m_t + 1;
        m_ph  = nph;
        m_req = nreq;
    endtask

    task automatic cyc(input logic [2:0] c, input logic m, input logic p);
        car   = c;
        modo  = m;
        pisca = p;
        @(negedge clk);
        obs = {verde, amarelo, vermelho, via_ativa};
        cmp("model", obs, model_out());
        model_step(c, m, p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 res = 1'b1;
        #1 cmp("async_reset", {verde, amarelo, vermelho, via_ativa},
               {3'b000, 3'b000, 3'b111, 2'd2});
        #1 res = 1'b0;
        m_ph  = 0;
        m_t   = 0;
        m_via = 2;
        m_req = '0;
    endtask

    function automatic vec_t mk(bit rs, logic [2:0] c, logic m, logic p,
                                int n, logic [2:0] v, logic [2:0] a,
                                logic [2:0] r, logic [1:0] via);
        vec_t e;
        e.rst   = rs;
        e.car   = c;
        e.modo  = m;
        e.pisca = p;
        e.n     = n;
        e.exp   = {v, a, r, via};
        return e;
    endfunction

    initial begin
        logic [2:0] rc;
        logic       rm, rp;

        tab.push_back(mk(1, 3'b000, 1, 0,  3, 3'b000, 3'b000, 3'b111, 2));
        tab.push_back(mk(0, 3'b000, 1, 0,  1, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 1, 0,  9, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 1, 0,  1, 3'b000, 3'b001, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 1, 0,  1, 3'b000, 3'b001, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 1, 0,  3, 3'b000, 3'b000, 3'b111, 0));
        tab.push_back(mk(0, 3'b000, 1, 0,  1, 3'b010, 3'b000, 3'b101, 1));
        tab.push_back(mk(0, 3'b000, 1, 0, 10, 3'b000, 3'b010, 3'b101, 1));
        tab.push_back(mk(0, 3'b000, 1, 0,  1, 3'b000, 3'b010, 3'b101, 1));
        tab.push_back(mk(0, 3'b000, 1, 0,  4, 3'b100, 3'b000, 3'b011, 2));
        tab.push_back(mk(0, 3'b000, 1, 0, 15, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 0, 0, 60, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(1, 3'b000, 1, 0,  4, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b100, 0, 0,  1, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 0, 0,  2, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 0, 0,  1, 3'b000, 3'b001, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 0, 0,  4, 3'b000, 3'b000, 3'b111, 0));
        tab.push_back(mk(0, 3'b000, 0, 0,  1, 3'b100, 3'b000, 3'b011, 2));
        tab.push_back(mk(1, 3'b000, 1, 0,  4, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b110, 0, 0,  1, 3'b001, 3'b000, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 0, 0,  3, 3'b000, 3'b001, 3'b110, 0));
        tab.push_back(mk(0, 3'b000, 0, 0,  5, 3'b010, 3'b000, 3'b101, 1));
        tab.push_back(mk(0, 3'b000, 0, 0,  4, 3'b000, 3'b010, 3'b101, 1));
        tab.push_back(mk(0, 3'b000, 0, 0,  5, 3'b100, 3'b000, 3'b011, 2));
        tab.push_back(mk(0, 3'b000, 0, 0, 40, 3'b100, 3'b000, 3'b011, 2));
        tab.push_back(mk(0, 3'b000, 0, 1,  1, 3'b100, 3'b000, 3'b011, 2));
        tab.push_back(mk(0, 3'b000, 0, 1,  1, 3'b000, 3'b111, 3'b000, 2));
        tab.push_back(mk(0, 3'b000, 0, 1,  1, 3'b000, 3'b111, 3'b000, 2));
        tab.push_back(mk(0, 3'b000, 0, 1,  1, 3'b000, 3'b000, 3'b000, 2));
        tab.push_back(mk(0, 3'b000, 0, 1,  1, 3'b000, 3'b000, 3'b000, 2));
        tab.push_back(mk(0, 3'b000, 0, 1,  1, 3'b000, 3'b111, 3'b000, 2));
        tab.push_back(mk(0, 3'b000, 0, 0,  1, 3'b000, 3'b111, 3'b000, 2));
        tab.push_back(mk(0, 3'b000, 0, 0,  1, 3'b000, 3'b000, 3'b111, 2));
        tab.push_back(mk(0, 3'b000, 0, 0,  2, 3'b000, 3'b000, 3'b111, 2));
        tab.push_back(mk(0, 3'b000, 0, 0,  1, 3'b100, 3'b000, 3'b011, 2));
        tab.push_back(mk(0, 3'b010, 1, 0, 10, 3'b000, 3'b100, 3'b011, 2));
        tab.push_back(mk(0, 3'b000, 1, 0,  5, 3'b010, 3'b000, 3'b101, 1));
        tab.push_back(mk(0, 3'b100, 1, 0, 10, 3'b000, 3'b010, 3'b101, 1));
        tab.push_back(mk(1, 3'b000, 1, 0,  4, 3'b001, 3'b000, 3'b110, 0));

        @(posedge clk);
        #1;

        foreach (tab[k]) begin
            if (tab[k].rst) do_reset();
            for (int j = 0; j < tab[k].n; j++)
                cyc(tab[k].car, tab[k].modo, tab[k].pisca);
            cmp($sformatf("vec%0d", k), obs, tab[k].exp);
        end

        do_reset();
        rm = 1'b1;
        rp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) rm = ~rm;
            if ($urandom_range(0, 39) == 0) rp = ~rp;
            for (int b = 0; b < N; b++)
                rc[b] = ($urandom_range(0, 11) == 0);
            cyc(rc, rm, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
